// File: rtl/mux_tree_pipe_pkg.sv
// mux_pkg: shared helpers for the pipelined mux tree.
//   word_count(sel_w, lvl) : number of DATA_W words held by tree level lvl,
//                            i.e. 2**(sel_w-1-lvl).
package mux_pkg;

  function automatic int unsigned word_count(input int unsigned sel_w,
                                             input int unsigned lvl);
    return 32'd1 << (sel_w - 32'd1 - lvl);
  endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// mux_tree_pipe_if: valid/ready bus of the pipelined mux tree.
//   d_in      : N_IN flattened channels, channel k = d_in[k*DATA_W +: DATA_W]
//   sel_in    : channel index, sampled with d_in
//   valid_in  : d_in/sel_in valid          ready_out : tree accepts input
//   y_out     : selected channel           valid_out : y_out valid
//   ready_in  : downstream accepts y_out
// master = producer/consumer side, slave = mux tree side.
interface mux_tree_pipe_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 2
);
  localparam int unsigned N_IN = 2 ** SEL_W;

  logic [N_IN*DATA_W-1:0] d_in;
  logic [SEL_W-1:0]       sel_in;
  logic                   valid_in;
  logic                   ready_out;
  logic [DATA_W-1:0]      y_out;
  logic                   valid_out;
  logic                   ready_in;

  modport master (
    output d_in, sel_in, valid_in, ready_in,
    input  ready_out, y_out, valid_out
  );

  modport slave (
    input  d_in, sel_in, valid_in, ready_in,
    output ready_out, y_out, valid_out
  );
endinterface

// File: rtl/mux_tree_pipe_stage.sv
// mux_2_1_stage: one registered level of the mux tree.
//   up_bus   : {carried select bits, this level's select bit, 2*N_PAIRS words}
//   up_valid : upstream valid
//   rdy_dn   : downstream stage (or output consumer) ready
//   rdy      : this stage can load this cycle (!dn_valid | rdy_dn)
//   dn_bus   : {carried select bits, N_PAIRS words}, registered
//   dn_valid : registered valid
// Word j of the output is pair (2j, 2j+1) of the input chosen by the select bit.
module mux_2_1_stage #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned N_PAIRS   = 1,
  parameter int unsigned SEL_REM_W = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [2*N_PAIRS*DATA_W+SEL_REM_W:0]  up_bus,
  input  logic                                 up_valid,
  input  logic                                 rdy_dn,
  output logic                                 rdy,
  output logic [N_PAIRS*DATA_W+SEL_REM_W-1:0]  dn_bus,
  output logic                                 dn_valid
);
  localparam int unsigned IN_D_W  = 2 * N_PAIRS * DATA_W;
  localparam int unsigned OUT_D_W = N_PAIRS * DATA_W;

  logic                           sel_bit;
  logic [OUT_D_W-1:0]             pick;
  logic [OUT_D_W+SEL_REM_W-1:0]   nxt;

  assign sel_bit = up_bus[IN_D_W];

  always_comb begin
    pick = '0;
    for (int unsigned j = 0; j < N_PAIRS; j++) begin
      pick[j*DATA_W +: DATA_W] = sel_bit ? up_bus[(2*j+1)*DATA_W +: DATA_W]
                                         : up_bus[(2*j)*DATA_W +: DATA_W];
    end
  end

  // The last level carries no select bits; keep the register width non-zero.
  if (SEL_REM_W > 0) begin : g_carry
    assign nxt = {up_bus[IN_D_W+SEL_REM_W -: SEL_REM_W], pick};
  end else begin : g_nocarry
    assign nxt = pick;
  end

  // Empty stage, or one whose contents leave this cycle, may load.
  assign rdy = !dn_valid || rdy_dn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_bus   <= '0;
      dn_valid <= 1'b0;
    end else if (rdy) begin
      dn_bus   <= nxt;
      dn_valid <= up_valid;
    end
  end
endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N:1 multiplexer, N = 2**SEL_W, built as SEL_W
// registered levels of 2:1 muxes; level s resolves sel bit s (LSB first).
// Latency SEL_W cycles, throughput 1/cycle, valid/ready backpressure with
// bubble collapsing.
//   clk_in   : rising-edge clock
//   rst_n_in : asynchronous active-low reset
//   bus      : mux_tree_pipe_if.slave (d_in, sel_in, valid_in, ready_out,
//              y_out, valid_out, ready_in)
// Build option MUX_TREE_ZERO_IDLE_EN: y_out forced to 0 while valid_out=0.
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  mux_tree_pipe_if.slave   bus
);
  for (genvar s = 0; s < SEL_W; s++) begin : g_lvl
    localparam int unsigned NP   = word_count(SEL_W, s);
    localparam int unsigned CW   = SEL_W - 1 - s;
    localparam int unsigned IN_W = 2 * NP * DATA_W + CW + 1;
    localparam int unsigned OW   = NP * DATA_W + CW;

    logic [IN_W-1:0] up_bus;
    logic            up_valid;
    logic            rdy_dn;
    logic            rdy;
    logic [OW-1:0]   dn_bus;
    logic            dn_valid;

    if (s == 0) begin : g_first
      assign up_bus   = {bus.sel_in, bus.d_in};
      assign up_valid = bus.valid_in;
    end else begin : g_mid
      assign up_bus   = g_lvl[s-1].dn_bus;
      assign up_valid = g_lvl[s-1].dn_valid;
    end

    if (s == SEL_W - 1) begin : g_out
      assign rdy_dn = bus.ready_in;
    end else begin : g_inner
      assign rdy_dn = g_lvl[s+1].rdy;
    end

    mux_2_1_stage #(
      .DATA_W    (DATA_W),
      .N_PAIRS   (NP),
      .SEL_REM_W (CW)
    ) u_stage (
      .clk      (clk_in),
      .rst_n    (rst_n_in),
      .up_bus   (up_bus),
      .up_valid (up_valid),
      .rdy_dn   (rdy_dn),
      .rdy      (rdy),
      .dn_bus   (dn_bus),
      .dn_valid (dn_valid)
    );
  end

  assign bus.ready_out = g_lvl[0].rdy;
  assign bus.valid_out = g_lvl[SEL_W-1].dn_valid;

`ifdef MUX_TREE_ZERO_IDLE_EN
  assign bus.y_out = g_lvl[SEL_W-1].dn_bus & {DATA_W{g_lvl[SEL_W-1].dn_valid}};
`else
  assign bus.y_out = g_lvl[SEL_W-1].dn_bus;
`endif
endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer built as a binary tree of 2:1 mux levels.
- Level s resolves select bit s, LSB first.
- One register stage per tree level; valid/ready handshake with backpressure and bubble collapsing.
- Generalises the fixed 4:1 selector for wide datapath channel selection at high clock rates.

Parameters:
- DATA_W, 8, width of each data channel in bits.
- SEL_W, 2, select width; N_IN = 2**SEL_W channels; SEL_W >= 1.

Ports:
- clk_in  input  1  rising-edge clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- d_in  input  N_IN*DATA_W  flattened channels; channel k = d_in[k*DATA_W +: DATA_W].
- sel_in  input  SEL_W  channel index, sampled with d_in.
- valid_in  input  1  d_in/sel_in valid this cycle.
- ready_out  output  1  block accepts input this cycle.
- y_out  output  DATA_W  selected channel.
- valid_out  output  1  y_out valid.
- ready_in  input  1  downstream accepts y_out.

Behaviour:
- Reset (rst_n_in low, asynchronous): all stage valid bits 0, all stage data and carried select bits 0; valid_out=0, y_out=0. ready_out may be 1 during reset (stage 0 empty). A transaction in flight when reset asserts is discarded.
- Stage s (0..SEL_W-1): register holding 2**(SEL_W-1-s) words of DATA_W, remaining select bits sel[SEL_W-1:s+1], and valid bit v[s].
- Stage 0 input: pair (2j, 2j+1) of d_in, chosen by sel_in[0].
- Stage s>0 input: pair (2j, 2j+1) of stage s-1 words, chosen by the carried select bit s.
- Output stage = stage SEL_W-1: y_out = its single word; valid_out = v[SEL_W-1].
- Per-stage ready: rdy[SEL_W-1] = !v[SEL_W-1] | ready_in; rdy[s] = !v[s] | rdy[s+1]; ready_out = rdy[0].
- Stage s loads when rdy[s]. It captures the upstream valid: valid_in for s=0, v[s-1] otherwise. When loading a 0 valid, data may update but valid goes 0.
- Transfer in: valid_in & ready_out. Transfer out: valid_out & ready_in.
- Latency: exactly SEL_W cycles from input transfer to valid_out when unstalled.
- Throughput: 1 per cycle.
- Stall: valid_out & !ready_in holds y_out/valid_out stable. Upstream empty stages keep filling until full; then ready_out=0. Bubbles collapse.
- Simultaneous output transfer and new data arriving at the last stage: the last stage reloads in the same cycle, with no gap.
- Ordering preserved; no data dropped or duplicated.
- Every sel_in value is legal; no error case.
- SEL_W=1: single stage, latency 1.

Optional Feature:
- Macro MUX_TREE_ZERO_IDLE_EN.
- Defined: y_out is forced to 0 whenever valid_out=0, i.e. AND-gated at the output.
- Undefined: y_out shows the last-stage register contents regardless of valid_out. No gating logic.

Decomposition:
- Package mux_pkg: function for the level-s word count, 2**(SEL_W-1-s).
- Sub-module mux_2_1_stage: one tree level. Parameters DATA_W and N_PAIRS. Handles the parallel 2:1 selects, data/select/valid registers, and the rdy equation.
- Top instantiates SEL_W stages via generate and adds the optional output gating.

Test Plan:
- Setup for all cases: DATA_W=8, SEL_W=2, d_in={8'h44,8'h33,8'h22,8'h11}, ready_in=1.
- Basic select: sel_in=2 with 1-cycle valid_in -> valid_out=1 exactly 2 cycles later, y_out=8'h33. Repeat for sel 0, 1, 3 -> 8'h11, 8'h22, 8'h44.
- Streaming: sel_in = 0,1,2,3 on consecutive cycles -> y_out = 11, 22, 33, 44 on consecutive cycles starting cycle 2.
- Backpressure: stream 4 words with ready_in=0 from cycle 2 -> ready_out=0 after the 2 stages fill. y_out holds 8'h11. On release, remaining words emerge in order with no loss or duplication.
- Bubble collapse: one word, 1-cycle gap, one word, with ready_in=0 -> both stages valid, ready_out=0. On release, back-to-back outputs.
- Reset mid-flight: assert rst_n_in asynchronously while 2 words are in flight -> valid_out=0 and y_out=0 immediately. After release, no stale output appears.
- Zero-idle option: with MUX_TREE_ZERO_IDLE_EN defined, y_out=0 on every cycle valid_out=0. Without it, y_out retains 8'h44 after the last transfer.
